gpu_sysid_ext: RTL
==================

GPU_SYSID_EXT -- requirements
Module: gpu_sysid_ext

Interface
REQ-001 SHALL have parameter SYSTEM_ID, default 911120: constant returned at word 0.
REQ-002 SHALL have parameter TIMESTAMP, default 1402342180: constant returned at word 1.
REQ-003 SHALL have parameter READ_LATENCY, default 1: cycles from read accept to readdatavalid; legal 1..4.
REQ-004 SHALL have parameter NUM_SCRATCH, default 2: number of R/W scratch words; legal 1..3.
REQ-005 SHALL have port clock  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port address  input  3: word address.
REQ-008 SHALL have port read  input  1: read request, accepted every cycle it is high.
REQ-009 SHALL have port write  input  1: write request, accepted every cycle it is high.
REQ-010 SHALL have port writedata  input  32: write data.
REQ-011 SHALL have port byteenable  input  4: byte lane enables for writes.
REQ-012 SHALL have port readdata  output  32: read data, valid only while readdatavalid is high.
REQ-013 SHALL have port readdatavalid  output  1: one-cycle pulse per accepted read.

Function
REQ-014 SHALL decode this word map: 0 SYSTEM_ID; 1 TIMESTAMP; 2 uptime[31:0]; 3 uptime snapshot[63:32]; 4 status; 5..4+NUM_SCRATCH scratch; every other address reads 0.
REQ-015 SHALL keep a 64-bit free-running uptime counter incrementing by 1 every clock and wrapping from 2^64-1 to 0.
REQ-016 SHALL, on an accepted read of word 2, return current uptime[31:0] and load the snapshot register with uptime[63:32] from the same cycle, so words 2 then 3 give a coherent 64-bit value.
REQ-017 SHALL, on a read of word 3, return the snapshot register unchanged.
REQ-018 SHALL format status as: [1:0] READ_LATENCY-1, [3:2] NUM_SCRATCH, [8] sticky collision flag, [9] sticky bad-write flag, all other bits 0.
REQ-019 SHALL sample read data in the accept cycle and present it READ_LATENCY cycles later through a READ_LATENCY-deep valid/data shift pipeline; back-to-back reads return in order, one per cycle.
REQ-020 SHALL hold readdata at its last value while readdatavalid is low.
REQ-021 SHALL update scratch words byte-wise, only lanes with byteenable high.
REQ-022 SHALL, on a write to word 2 with writedata[0]=1, clear the uptime counter to 0 on the next edge; other writedata values have no effect.
REQ-023 SHALL, on a write to word 4, clear status[8] if writedata[8]=1 and status[9] if writedata[9]=1.
REQ-024 SHALL, on a write to words 0, 1, 3 or any unmapped address, ignore the data and set status[9].
REQ-025 SHALL, when read and write are high in the same cycle, perform the read, drop the write, and set status[8].
REQ-026 SHALL, when a flag clear and a flag set coincide in one cycle, leave the flag set.
REQ-027 SHALL, for a read and a state change on the same word in one cycle, return the pre-update value.

Reset
REQ-028 SHALL, while reset_n is low, force readdatavalid 0, readdata 0, uptime 0, snapshot 0, all scratch 0, status flags 0, and clear the read pipeline.
REQ-029 SHALL discard reads in flight when reset asserts mid-operation; no readdatavalid pulse for them after release.
REQ-030 SHALL start uptime counting on the first rising edge after reset_n deasserts.

Verification
REQ-031 Defaults, reads of 0,1,7 back-to-back -> readdatavalid high 3 consecutive cycles, data 911120, 1402342180, 0.
REQ-032 READ_LATENCY=3, single read of word 4 -> readdatavalid exactly 3 cycles later, data 0x0000_000A.
REQ-033 Force uptime to 0x0000_0000_FFFF_FFFF, read word 2 then word 3 -> 0xFFFF_FFFF then 0x0000_0000; counter wraps to 0x1_0000_0000 next cycle.
REQ-034 Write 0xAABBCCDD with byteenable 4'b0101 to word 5 (prior 0) -> read returns 0x00BB00DD.
REQ-035 Read+write same cycle on word 5, then write word 0 -> write dropped, status reads 0x30A; write 0x300 to word 4 -> status 0x00A.
REQ-036 Assert reset_n low during 2 outstanding reads (READ_LATENCY=4) -> no readdatavalid after release, all outputs 0.

Source files
------------

// File: rtl/gpu_sysid_ext.sv
// System-ID / uptime register block: constant ID words, a 64-bit uptime counter
// with coherent high-word snapshot, a status word, and byte-writable scratch words.
module gpu_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'd911120,
  parameter logic [31:0] TIMESTAMP    = 32'd1402342180,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned NUM_SCRATCH  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] A_SYSID  = 3'd0;
  localparam logic [2:0] A_TSTAMP = 3'd1;
  localparam logic [2:0] A_UP_LO  = 3'd2;
  localparam logic [2:0] A_UP_HI  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic        coll_q, coll_d;
  logic        bad_q, bad_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0] pdata_q [READ_LATENCY];
  logic [31:0] pdata_d [READ_LATENCY];

  logic        wr_acc;
  logic        is_scratch;
  logic        bad_wr;
  logic [31:0] status;
  logic [31:0] rdata;

  always_comb begin
    wr_acc     = write & ~read;
    is_scratch = 1'b0;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (address == 3'(5 + i)) is_scratch = 1'b1;
    end
    bad_wr = wr_acc && (address == A_SYSID || address == A_TSTAMP ||
                        address == A_UP_HI || (address > A_STATUS && !is_scratch));

    status       = '0;
    status[1:0]  = 2'(READ_LATENCY - 1);
    status[3:2]  = 2'(NUM_SCRATCH);
    status[8]    = coll_q;
    status[9]    = bad_q;

    // Read mux works on current (pre-update) state so same-cycle writes are not visible.
    case (address)
      A_SYSID:  rdata = SYSTEM_ID;
      A_TSTAMP: rdata = TIMESTAMP;
      A_UP_LO:  rdata = uptime_q[31:0];
      A_UP_HI:  rdata = snap_q;
      A_STATUS: rdata = status;
      default: begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (address == 3'(5 + i)) rdata = scratch_q[i];
        end
      end
    endcase
  end

  always_comb begin
    uptime_d = uptime_q + 64'd1;
    if (wr_acc && address == A_UP_LO && writedata[0]) uptime_d = '0;

    snap_d = snap_q;
    if (read && address == A_UP_LO) snap_d = uptime_q[63:32];

    scratch_d = scratch_q;
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      if (wr_acc && address == 3'(5 + i)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end

    // Clears first, sets afterwards so a coincident set wins.
    coll_d = coll_q;
    bad_d  = bad_q;
    if (wr_acc && address == A_STATUS) begin
      if (writedata[8]) coll_d = 1'b0;
      if (writedata[9]) bad_d  = 1'b0;
    end
    if (read && write) coll_d = 1'b1;
    if (bad_wr)        bad_d  = 1'b1;

    // Each stage only captures data when a valid enters it, so the tail holds its last value.
    vld_d[0]   = read;
    pdata_d[0] = read ? rdata : pdata_q[0];
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      pdata_d[i] = vld_q[i-1] ? pdata_q[i-1] : pdata_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q <= '0;
      snap_q   <= '0;
      coll_q   <= 1'b0;
      bad_q    <= 1'b0;
      vld_q    <= '0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) pdata_q[i] <= '0;
    end else begin
      uptime_q <= uptime_d;
      snap_q   <= snap_d;
      coll_q   <= coll_d;
      bad_q    <= bad_d;
      vld_q    <= vld_d;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
      for (int unsigned i = 0; i < READ_LATENCY; i++) pdata_q[i] <= pdata_d[i];
    end
  end

  assign readdata      = pdata_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule
